// File: rtl/bit_unpermute_stream.sv
// bit_unpermute_stream
// Receive-side inverse of a fixed bit permutation. The forward map P is
// loaded one entry per beat over the config port and inverted on the fly
// into Q (Q[P[j]] = j). Once the table is complete, a 2-stage valid/ready
// pipeline restores canonical bit order: out_data[i] = in_data[Q[i]].
module bit_unpermute_stream #(
   parameter int WIDTH = 8,
   parameter int IDXW  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   // configuration port
   input  logic             cfg_start,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IDXW-1:0]  cfg_idx,
   output logic             cfg_done,
   output logic             cfg_error,
   // input stream (permuted words)
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   // output stream (restored words)
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);

   typedef enum logic [1:0] {
      ST_UNCFG = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ERR   = 2'd2,
      ST_RUN   = 2'd3
   } state_e;

   // WIDTH expressed one bit wider than an index so out-of-range indices
   // (possible when WIDTH is not a power of two) compare correctly.
   localparam logic [IDXW:0]   WIDTH_W = (IDXW+1)'(WIDTH);
   localparam logic [IDXW-1:0] LAST_J  = IDXW'(WIDTH-1);

   // control state
   state_e             state_q, state_d;
   logic               pend_q, pend_d;     // reload requested while running
   logic [IDXW-1:0]    j_q, j_d;           // beat counter during load
   logic [WIDTH-1:0]   seen_q, seen_d;     // indices already used in this load
   logic               tbl_we;             // write Q[cfg_idx] = j this cycle

   // inverse table
   logic [IDXW-1:0]    q_q [WIDTH];

   // datapath
   logic               s1_valid_q;
   logic [WIDTH-1:0]   s1_data_q;
   logic               out_valid_q;
   logic [WIDTH-1:0]   out_data_q;
   logic [WIDTH-1:0]   perm_word;
   logic               adv;
   logic               in_fire;
   logic               idx_ok;

   assign idx_ok  = ({1'b0, cfg_idx} < WIDTH_W);
   assign adv     = !out_valid_q || out_ready;
   assign in_fire = in_valid && in_ready;

   assign cfg_done  = (state_q == ST_RUN);
   assign cfg_error = (state_q == ST_ERR);
   assign in_ready  = (state_q == ST_RUN) && !pend_q && adv;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // Next-state logic for the load/run controller and the config handshake.
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so
      // no path through the case leaves a value unassigned (no latches).
      state_d   = state_q;
      pend_d    = pend_q;
      j_d       = j_q;
      seen_d    = seen_q;
      tbl_we    = 1'b0;
      cfg_ready = 1'b0;

      case (state_q)
         ST_UNCFG, ST_ERR: begin
            if (cfg_start) begin
               state_d = ST_LOAD;
               j_d     = '0;
               seen_d  = '0;
            end
         end

         ST_LOAD: begin
            cfg_ready = !cfg_start;
            if (cfg_start) begin
               // restart the load from beat 0
               j_d    = '0;
               seen_d = '0;
            end else if (cfg_valid) begin
               if (!idx_ok || seen_q[cfg_idx]) begin
                  state_d = ST_ERR;
               end else begin
                  tbl_we          = 1'b1;
                  seen_d[cfg_idx] = 1'b1;
                  if (j_q == LAST_J) begin
                     state_d = ST_RUN;
                  end else begin
                     j_d = j_q + 1'b1;
                  end
               end
            end
         end

         ST_RUN: begin
            if (cfg_start) begin
               pend_d = 1'b1;
            end
            // reload only once every word accepted under the old table is out
            if (pend_q && !s1_valid_q && !out_valid_q) begin
               state_d = ST_LOAD;
               pend_d  = 1'b0;
               j_d     = '0;
               seen_d  = '0;
            end
         end

         default: begin
            state_d = ST_UNCFG;
         end
      endcase
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q <= ST_UNCFG;
         pend_q  <= 1'b0;
         j_q     <= '0;
         seen_q  <= '0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         j_q     <= j_d;
         seen_q  <= seen_d;
      end
   end

   // Inverse table: accepted beat j stores j at position P[j].
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the table is small and held in flops, so it is reset like any
      // other register; a RAM-based table would normally not be reset.
      if (!rst_n) begin
         for (int i = 0; i < WIDTH; i++) begin
            q_q[i] <= '0;
         end
      end else if (tbl_we) begin
         q_q[cfg_idx] <= j_q;
      end
   end

   // Restore bit order of the stage-1 word through the inverse table.
   always_comb begin
      perm_word = '0;
      for (int i = 0; i < WIDTH; i++) begin
         perm_word[i] = s1_data_q[q_q[i]];
      end
   end

   // Two-stage pipeline with a single global stall (adv).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (adv) begin
         s1_valid_q  <= in_fire;
         if (in_fire) begin
            s1_data_q <= in_data;
         end
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            out_data_q <= perm_word;
         end
      end
   end

endmodule

// File: tb/tb_bit_unpermute_stream.sv
// Testbench for bit_unpermute_stream (WIDTH=8).
// Directed table vectors, multi-cycle corner sequences, and randomized
// streams scored against a forward-rule model: out[P[j]] = in[j].
module tb_bit_unpermute_stream;

   localparam int W  = 8;
   localparam int IW = 3;

   typedef logic [IW-1:0] perm_t [W];

   typedef struct {
      int           psel;
      logic [W-1:0] din;
      logic [W-1:0] dout;
   } vec_t;

   logic          clk;
   logic          rst_n;
   logic          cfg_start;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [IW-1:0] cfg_idx;
   logic          cfg_done;
   logic          cfg_error;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_data;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;

   int n_tests = 0;
   int n_fail  = 0;
   int n_acc   = 0;

   perm_t        cur_perm;
   perm_t        perms [3];
   vec_t         vecs [6];
   logic [W-1:0] sb [$];
   bit           holding;
   logic [W-1:0] held;

   bit_unpermute_stream #(.WIDTH(W), .IDXW(IW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_idx   (cfg_idx),
      .cfg_done  (cfg_done),
      .cfg_error (cfg_error),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // forward rule: the bit at position j of the permuted word came from P[j]
   function automatic logic [W-1:0] model(input perm_t p, input logic [W-1:0] d);
      logic [W-1:0] r;
      r = '0;
      for (int j = 0; j < W; j++) r[p[j]] = d[j];
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // scoreboard: record accepted words, compare delivered words, hold check
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) begin
            sb.push_back(model(cur_perm, in_data));
            n_acc++;
         end
         if (holding && out_valid) check("hold_stable", out_data, held);
         holding = out_valid && !out_ready;
         held    = out_data;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL stream_extra: got %0h expected no word", out_data);
            end else begin
               check("stream", out_data, sb.pop_front());
            end
         end
      end else begin
         sb.delete();
         holding = 1'b0;
      end
   end

   task automatic load_table(input perm_t p, input bit do_start, output int cyc, output int beats);
      int w;
      cyc   = 0;
      beats = 0;
      if (do_start) begin
         cfg_start = 1'b1;
         tick();
         cfg_start = 1'b0;
         cyc = 1;
      end
      for (int j = 0; j < W; j++) begin
         cfg_valid = 1'b1;
         cfg_idx   = p[j];
         #1;
         w = 0;
         while (!cfg_ready && !cfg_error && w < 100) begin
            tick();
            #1;
            w++;
            cyc++;
         end
         if (cfg_error) break;
         if (!cfg_ready) begin
            fail_now("load_beat");
            break;
         end
         tick();
         cyc++;
         beats++;
      end
      cfg_valid = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] d);
      int w;
      in_valid = 1'b1;
      in_data  = d;
      #1;
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         #1;
         w++;
      end
      if (!in_ready) fail_now("send");
      tick();
      in_valid = 1'b0;
   endtask

   task automatic get_word(output logic [W-1:0] d, output int lat);
      out_ready = 1'b1;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!out_valid) fail_now("get_word");
      d = out_data;
      tick();
   endtask

   task automatic run_stream(input int ncyc, input int vp, input int rp, input int s0, input int sl);
      bit stall;
      for (int c = 0; c < ncyc; c++) begin
         stall     = (c >= s0) && (c < s0 + sl);
         in_valid  = ($urandom_range(99) < vp);
         in_data   = W'($urandom);
         out_ready = stall ? 1'b0 : ($urandom_range(99) < rp);
         #1;
         if (stall && out_valid) check("bp_in_ready", in_ready, 1'b0);
         tick();
      end
   endtask

   task automatic drain();
      int w;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      w = 0;
      while (sb.size() != 0 && w < 50) begin
         tick();
         w++;
      end
      check("drain_empty", sb.size(), 0);
   endtask

   initial begin
      int           cyc;
      int           beats;
      int           lat;
      int           loaded;
      int           acc0;
      int           w;
      int           r;
      logic [W-1:0] got;
      logic [IW-1:0] tmp;
      perm_t        p_err;
      perm_t        p_rnd;

      for (int k = 0; k < W; k++) begin
         perms[0][k] = IW'(k);
         perms[1][k] = IW'(W - 1 - k);
      end
      perms[2] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd4, 3'd6, 3'd7};
      p_err    = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};

      vecs[0] = '{psel: 0, din: 8'hA5, dout: 8'hA5};
      vecs[1] = '{psel: 1, din: 8'h01, dout: 8'h80};
      vecs[2] = '{psel: 1, din: 8'h0E, dout: 8'h70};
      vecs[3] = '{psel: 2, din: 8'h01, dout: 8'h02};
      vecs[4] = '{psel: 2, din: 8'h08, dout: 8'h01};
      vecs[5] = '{psel: 2, din: 8'h10, dout: 8'h20};

      cur_perm  = perms[0];
      rst_n     = 1'b0;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_idx   = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      // reset values
      #1;
      check("rst_cfg_ready", cfg_ready, 1'b0);
      check("rst_cfg_done",  cfg_done,  1'b0);
      check("rst_cfg_error", cfg_error, 1'b0);
      check("rst_in_ready",  in_ready,  1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_data",  out_data,  8'h00);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // unconfigured: nothing accepted
      in_valid = 1'b1;
      in_data  = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("uncfg_in_ready",  in_ready,  1'b0);
         check("uncfg_cfg_ready", cfg_ready, 1'b0);
         tick();
      end
      in_valid = 1'b0;

      // identity load from UNCFG: cfg_ready next cycle, done 9 cycles after start
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      #1;
      check("start_cfg_ready", cfg_ready, 1'b1);
      load_table(perms[0], 1'b0, cyc, beats);
      check("ident_done_cycles", cyc + 1, 9);
      check("ident_cfg_done", cfg_done, 1'b1);
      cur_perm = perms[0];
      loaded   = 0;

      // table-driven vectors
      for (int v = 0; v < 6; v++) begin
         if (vecs[v].psel != loaded) begin
            load_table(perms[vecs[v].psel], 1'b1, cyc, beats);
            check($sformatf("vec%0d_loaded", v), cfg_done, 1'b1);
            cur_perm = perms[vecs[v].psel];
            loaded   = vecs[v].psel;
         end
         send(vecs[v].din);
         get_word(got, lat);
         check($sformatf("vec%0d_data", v), got, vecs[v].dout);
         check($sformatf("vec%0d_latency", v), lat, 1);
      end

      // reconfigure with two words in flight (shuffle table still loaded)
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h01;
      #1;
      check("rc_in_ready_a", in_ready, 1'b1);
      tick();
      in_data   = 8'h08;
      cfg_start = 1'b1;
      #1;
      check("rc_in_ready_t", in_ready, 1'b1);
      tick();
      cfg_start = 1'b0;
      in_valid  = 1'b0;
      #1;
      check("rc_in_ready_t1", in_ready, 1'b0);
      check("rc_done_pend",   cfg_done, 1'b1);
      check("rc_old_valid1",  out_valid, 1'b1);
      check("rc_old_data1",   out_data, 8'h02);
      tick();
      check("rc_old_valid2",  out_valid, 1'b1);
      check("rc_old_data2",   out_data, 8'h01);
      #1;
      w = 0;
      while (!cfg_ready && w < 20) begin
         tick();
         #1;
         w++;
      end
      if (!cfg_ready) fail_now("rc_enter_load");
      check("rc_done_dropped", cfg_done, 1'b0);
      load_table(perms[1], 1'b0, cyc, beats);
      check("rc_reloaded", cfg_done, 1'b1);
      cur_perm = perms[1];
      send(8'h01);
      get_word(got, lat);
      check("rc_new_table", got, 8'h80);

      // back-to-back stream, one word per cycle
      acc0 = n_acc;
      run_stream(16, 100, 100, -1, 0);
      check("throughput", n_acc - acc0, 16);
      drain();

      // backpressure: out_ready low for 5 cycles mid-stream
      run_stream(20, 100, 100, 8, 5);
      drain();

      // error load: duplicate index on the 4th beat
      load_table(p_err, 1'b1, cyc, beats);
      check("err_beats", beats, 4);
      check("err_flag",  cfg_error, 1'b1);
      check("err_ready", cfg_ready, 1'b0);
      check("err_done",  cfg_done, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      for (int c = 0; c < 3; c++) begin
         #1;
         check("err_in_ready",  in_ready,  1'b0);
         check("err_out_valid", out_valid, 1'b0);
         tick();
      end
      in_valid  = 1'b0;
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      #1;
      check("recover_cfg_ready", cfg_ready, 1'b1);
      check("recover_cfg_error", cfg_error, 1'b0);
      load_table(perms[0], 1'b0, cyc, beats);
      check("recover_done",  cfg_done,  1'b1);
      check("recover_error", cfg_error, 1'b0);
      cur_perm = perms[0];
      send(8'h3C);
      get_word(got, lat);
      check("recover_data", got, 8'h3C);

      // reset mid-stream: words dropped, back to unconfigured
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_data = W'($urandom);
         tick();
      end
      rst_n = 1'b0;
      #1;
      check("mrst_out_valid", out_valid, 1'b0);
      check("mrst_out_data",  out_data, 8'h00);
      check("mrst_cfg_done",  cfg_done, 1'b0);
      check("mrst_in_ready",  in_ready, 1'b0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         in_data = W'($urandom);
         #1;
         check("mrst_blocked_in",  in_ready,  1'b0);
         check("mrst_blocked_out", out_valid, 1'b0);
         tick();
      end
      in_valid = 1'b0;

      // randomized permutations and traffic
      for (int t = 0; t < 3; t++) begin
         for (int k = 0; k < W; k++) p_rnd[k] = IW'(k);
         for (int k = W - 1; k > 0; k--) begin
            r        = $urandom_range(k);
            tmp      = p_rnd[k];
            p_rnd[k] = p_rnd[r];
            p_rnd[r] = tmp;
         end
         load_table(p_rnd, 1'b1, cyc, beats);
         check("rnd_loaded", cfg_done, 1'b1);
         cur_perm = p_rnd;
         run_stream(200, 70, 70, -1, 0);
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
